counter_rr_scheduler: RTL and testbench
=======================================

// Module: counter_rr_scheduler
// PURPOSE
//  Shares one WIDTH-bit step counter between NUM_REQ requesters. Round-robin arbiter grants
//  one requester per cycle; the granted step is added to the shared value and acknowledged.
//  Bursts and a clear request are supported. Sits between requesting blocks and the count datapath.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  WIDTH      32  shared counter width
//  STEP_W     8   per-requester step width, zero-extended to WIDTH
//  BURST_MAX  4   max consecutive grants to one owner while others wait (>=1)
// PORTS
//  clock      in   1                 all state updates on falling edge
//  clear_n    in   1                 async active-low reset
//  req        in   NUM_REQ           level request, bit i = requester i
//  step       in   NUM_REQ*STEP_W    step[i*STEP_W +: STEP_W] for requester i
//  clr_req    in   1                 synchronous request to zero value
//  ack        out  NUM_REQ           one-hot, 1-cycle pulse: step of that requester applied
//  owner      out  clog2(NUM_REQ)    index of current/last owner
//  busy       out  1                 high in SERVE state
//  value      out  WIDTH             shared counter
//  wrapped    out  1                 sticky: an add overflowed WIDTH
// BEHAVIOUR
//  Reset (clear_n=0, any time, mid-burst included): value=0, wrapped=0, ack=0, owner=0,
//   busy=0, rr pointer=0, burst count=0, state=IDLE. Takes effect immediately, no clock needed.
//  FSM, evaluated each falling edge:
//   IDLE : clr_req -> value=0, wrapped=0, stay IDLE, no ack. Else if any req -> pick owner,
//          add its step, pulse ack[owner], burst=1, go SERVE. Else hold.
//   SERVE: clr_req -> value=0, wrapped=0, no ack, burst=0, go IDLE (clear beats every req).
//          Else if req[owner] && (burst<BURST_MAX || no other req) -> add step[owner],
//          ack[owner], burst=min(burst+1,BURST_MAX). Else if other req -> rotate: new
//          owner chosen, add its step, ack, burst=1. Else -> IDLE, no ack.
//  Owner selection: first asserted req scanning from rr pointer upward, wrapping NUM_REQ-1->0;
//   on each selection rr pointer = owner+1 mod NUM_REQ. Owner never reselected ahead of a
//   waiting requester once BURST_MAX reached.
//  Latency: ack and updated value visible after the same falling edge that samples req;
//   exactly one ack bit per edge max; ack never set without value update.
//  Arithmetic: value <= value + zero_ext(step) mod 2^WIDTH; carry-out sets wrapped (sticky
//   until reset or clr_req). step=0 still grants and acks, value unchanged.
//  Requester may drop req any edge; no ack issued to a requester whose req is low at the edge.
//  clr_req and req same edge: clear only, req stays pending, served next edge.
//  busy=1 exactly while state=SERVE; owner holds last value in IDLE.
// TESTING
//  1 Reset: clear_n=0 mid-burst with value=9 -> value=0, ack=0, busy=0 asynchronously.
//  2 Single req: req=0001, step0=3, 4 edges -> value 3,6,9,12; ack=0001 each edge.
//  3 Fairness: req=1111, steps 1,2,3,4, BURST_MAX=1 -> ack order 0,1,2,3,0; value 1,3,6,10,11.
//  4 Burst: req=0011, step0=5, step1=1, BURST_MAX=4 -> four acks to 0 (value 20), then 1 (21).
//  5 Clear priority: req=0001, clr_req=1 with value=12 -> value=0, no ack, IDLE; next edge 3.
//  6 Wrap: value=32'hFFFFFFFE, step=3 -> value=1, wrapped=1; stays 1 until clr_req.

Source files
------------

// File: rtl/counter_rr_scheduler.sv
// Round-robin arbiter sharing one WIDTH-bit accumulating counter between NUM_REQ requesters.
// All state updates on the falling clock edge; clear_n resets asynchronously.
module counter_rr_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned BURST_W  = $clog2(BURST_MAX + 1)
) (
  input  logic                      clock,
  input  logic                      clear_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*STEP_W-1:0] step,
  input  logic                      clr_req,
  output logic [NUM_REQ-1:0]        ack,
  output logic [OWN_W-1:0]          owner,
  output logic                      busy,
  output logic [WIDTH-1:0]          value,
  output logic                      wrapped
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SERVE = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [OWN_W-1:0]   rr_q, rr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [OWN_W-1:0]   owner_d;
  logic [WIDTH-1:0]   value_d;
  logic               wrapped_d;

  logic               sel_found;
  logic [OWN_W-1:0]   sel_idx;
  logic [OWN_W-1:0]   cand;
  logic               others;
  logic               burst_lt;
  logic               grant;
  logic               newsel;
  logic [OWN_W-1:0]   grant_idx;
  logic [STEP_W-1:0]  step_g;
  logic [WIDTH:0]     sum;

  // First asserted request scanning upward from the rr pointer, wrapping to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = OWN_W'((32'(rr_q) + i) % NUM_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign others   = |(req & ~(NUM_REQ'(1) << owner));
  assign burst_lt = (burst_q < BURST_W'(BURST_MAX));

  // Next-state, grant decision and counter datapath.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    burst_d   = burst_q;
    ack_d     = '0;
    owner_d   = owner;
    value_d   = value;
    wrapped_d = wrapped;
    grant     = 1'b0;
    newsel    = 1'b0;
    grant_idx = owner;
    step_g    = '0;
    sum       = '0;

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          value_d   = '0;
          wrapped_d = 1'b0;
        end else if (sel_found) begin
          grant     = 1'b1;
          newsel    = 1'b1;
          grant_idx = sel_idx;
          state_d   = S_SERVE;
        end
      end
      S_SERVE: begin
        if (clr_req) begin
          value_d   = '0;
          wrapped_d = 1'b0;
          burst_d   = '0;
          state_d   = S_IDLE;
        end else if (req[owner] && (burst_lt || !others)) begin
          grant     = 1'b1;
          grant_idx = owner;
          if (burst_lt) burst_d = burst_q + BURST_W'(1);
        end else if (others) begin
          grant     = 1'b1;
          newsel    = 1'b1;
          grant_idx = sel_idx;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (OWN_W'(i) == grant_idx) step_g = step[i*STEP_W +: STEP_W];
    end

    if (grant) begin
      sum       = {1'b0, value} + {{(WIDTH + 1 - STEP_W){1'b0}}, step_g};
      value_d   = sum[WIDTH-1:0];
      wrapped_d = wrapped | sum[WIDTH];
      ack_d     = NUM_REQ'(1) << grant_idx;
    end

    if (newsel) begin
      owner_d = grant_idx;
      rr_d    = (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : grant_idx + OWN_W'(1);
      burst_d = BURST_W'(1);
    end
  end

  always_ff @(negedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      burst_q <= '0;
      ack     <= '0;
      owner   <= '0;
      value   <= '0;
      wrapped <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      ack     <= ack_d;
      owner   <= owner_d;
      value   <= value_d;
      wrapped <= wrapped_d;
    end
  end

  assign busy = (state_q == S_SERVE);

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: two instances (32-bit/burst 4 and 8-bit/burst 1) on shared
// stimulus, each compared against a queue-free behavioural model of the arbitration rules.
module tb_counter_rr_scheduler;

  logic        clock;
  logic        clear_n;
  logic [3:0]  req;
  logic [31:0] step;
  logic        clr_req;

  logic [3:0]  ack0, ack1;
  logic [1:0]  owner0, owner1;
  logic        busy0, busy1;
  logic [31:0] value0;
  logic [7:0]  value1;
  logic        wrapped0, wrapped1;

  int n_tests = 0;
  int n_fail  = 0;

  counter_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .STEP_W(8), .BURST_MAX(4)) u_dut0 (
    .clock(clock), .clear_n(clear_n), .req(req), .step(step), .clr_req(clr_req),
    .ack(ack0), .owner(owner0), .busy(busy0), .value(value0), .wrapped(wrapped0));

  counter_rr_scheduler #(.NUM_REQ(4), .WIDTH(8), .STEP_W(8), .BURST_MAX(1)) u_dut1 (
    .clock(clock), .clear_n(clear_n), .req(req), .step(step), .clr_req(clr_req),
    .ack(ack1), .owner(owner1), .busy(busy1), .value(value1), .wrapped(wrapped1));

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // Model state per instance: is anyone being served, who, next scan start, run length.
  int     bm[2]  = '{4, 1};
  longint md[2]  = '{64'h1_0000_0000, 256};
  bit     m_serv[2];
  int     m_own[2];
  int     m_ptr[2];
  int     m_run[2];
  longint m_val[2];
  bit     m_wrap[2];
  int     m_ack[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_serv[k] = 0; m_own[k] = 0; m_ptr[k] = 0; m_run[k] = 0;
      m_val[k] = 0; m_wrap[k] = 0; m_ack[k] = 0;
    end
  endtask

  function automatic int first_req(int k);
    for (int i = 0; i < 4; i++) begin
      if (req[(m_ptr[k] + i) % 4]) return (m_ptr[k] + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(int k);
    int g;
    bit newsel;
    bit oth;
    longint s;
    m_ack[k] = 0;
    if (clr_req) begin
      m_val[k] = 0; m_wrap[k] = 0; m_serv[k] = 0; m_run[k] = 0;
      return;
    end
    oth = 0;
    for (int i = 0; i < 4; i++) if (i != m_own[k] && req[i]) oth = 1;
    g = -1; newsel = 0;
    if (!m_serv[k]) begin
      g = first_req(k); newsel = 1;
    end else if (req[m_own[k]] && (m_run[k] < bm[k] || !oth)) begin
      g = m_own[k];
    end else if (oth) begin
      g = first_req(k); newsel = 1;
    end
    if (g < 0) begin
      m_serv[k] = 0;
    end else begin
      s = m_val[k] + longint'(step[g*8 +: 8]);
      if (s >= md[k]) begin m_wrap[k] = 1; s = s - md[k]; end
      m_val[k] = s;
      m_ack[k] = 1 << g;
      m_serv[k] = 1;
      if (newsel) begin
        m_own[k] = g; m_ptr[k] = (g + 1) % 4; m_run[k] = 1;
      end else if (m_run[k] < bm[k]) begin
        m_run[k]++;
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "/ack0"},   64'(ack0),     64'(m_ack[0]));
    chk({tag, "/own0"},   64'(owner0),   64'(m_own[0]));
    chk({tag, "/busy0"},  64'(busy0),    64'(m_serv[0]));
    chk({tag, "/val0"},   64'(value0),   64'(m_val[0]));
    chk({tag, "/wrap0"},  64'(wrapped0), 64'(m_wrap[0]));
    chk({tag, "/ack1"},   64'(ack1),     64'(m_ack[1]));
    chk({tag, "/own1"},   64'(owner1),   64'(m_own[1]));
    chk({tag, "/busy1"},  64'(busy1),    64'(m_serv[1]));
    chk({tag, "/val1"},   64'(value1),   64'(m_val[1]));
    chk({tag, "/wrap1"},  64'(wrapped1), 64'(m_wrap[1]));
  endtask

  // Drive inputs well away from the falling edge, then check just after it.
  task automatic do_edge(logic [3:0] r, logic [31:0] s, logic c, string tag);
    req = r; step = s; clr_req = c;
    @(negedge clock);
    #1;
    model_edge(0);
    model_edge(1);
    check_all(tag);
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock edge.
  task automatic do_reset(string tag);
    clear_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    clear_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r;
    logic [31:0] s;
    logic        c;
    clear_n = 1'b0; req = '0; step = '0; clr_req = 1'b0;
    #1;
    model_reset();
    check_all("reset0");
    @(negedge clock);
    #2;
    clear_n = 1'b1;

    // Mid-burst async reset with value 9
    for (int i = 0; i < 3; i++) do_edge(4'b0001, 32'h0000_0003, 1'b0, "pre_rst");
    chk("rst_pre_val", 64'(value0), 64'd9);
    do_reset("rst_mid");
    chk("rst_val", 64'(value0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);

    // Single requester: 3,6,9,12
    for (int i = 0; i < 4; i++) begin
      do_edge(4'b0001, 32'h0000_0003, 1'b0, "single");
      chk("single_val", 64'(value0), 64'(3 * (i + 1)));
      chk("single_ack", 64'(ack0), 64'd1);
    end

    // Clear beats request; request served next edge
    do_edge(4'b0001, 32'h0000_0003, 1'b1, "clr");
    chk("clr_val", 64'(value0), 64'd0);
    chk("clr_ack", 64'(ack0), 64'd0);
    chk("clr_busy", 64'(busy0), 64'd0);
    do_edge(4'b0001, 32'h0000_0003, 1'b0, "clr_next");
    chk("clr_next_val", 64'(value0), 64'd3);

    // Fairness on the burst-1 instance: ack order 0,1,2,3,0
    do_reset("rst_fair");
    begin
      int exp_ack[5] = '{1, 2, 4, 8, 1};
      int exp_val[5] = '{1, 3, 6, 10, 11};
      for (int i = 0; i < 5; i++) begin
        do_edge(4'b1111, 32'h0403_0201, 1'b0, "fair");
        chk("fair_ack1", 64'(ack1), 64'(exp_ack[i]));
        chk("fair_val1", 64'(value1), 64'(exp_val[i]));
      end
    end

    // Burst limit on the burst-4 instance: four to 0, then 1
    do_reset("rst_burst");
    begin
      int exp_ack[5] = '{1, 1, 1, 1, 2};
      int exp_val[5] = '{5, 10, 15, 20, 21};
      for (int i = 0; i < 5; i++) begin
        do_edge(4'b0011, 32'h0000_0105, 1'b0, "burst");
        chk("burst_ack0", 64'(ack0), 64'(exp_ack[i]));
        chk("burst_val0", 64'(value0), 64'(exp_val[i]));
      end
    end

    // Wrap on the 8-bit instance: 0xFE + 3 -> 1, sticky until clear
    do_reset("rst_wrap");
    do_edge(4'b0001, 32'h0000_00FE, 1'b0, "wrap_load");
    do_edge(4'b0001, 32'h0000_0003, 1'b0, "wrap");
    chk("wrap_val1", 64'(value1), 64'd1);
    chk("wrap_flag1", 64'(wrapped1), 64'd1);
    do_edge(4'b0000, 32'h0000_0000, 1'b0, "wrap_hold");
    chk("wrap_hold1", 64'(wrapped1), 64'd1);
    do_edge(4'b0000, 32'h0000_0000, 1'b1, "wrap_clr");
    chk("wrap_clr1", 64'(wrapped1), 64'd0);

    // Step of zero still acks
    do_edge(4'b0100, 32'h0000_0000, 1'b0, "zero_step");
    chk("zero_ack0", 64'(ack0), 64'd4);

    // Randomized traffic against the model
    do_reset("rst_rand");
    for (int n = 0; n < 600; n++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      s = $urandom;
      c = ($urandom_range(0, 31) == 0);
      do_edge(r, s, c, "rand");
      if ($urandom_range(0, 149) == 0) do_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
